// File: rtl/pos_lut_sweep.sv
// Programmable N_IN-input truth-table cell with live evaluation and a
// self-driven sweep that emits every minterm and counts the ones.
module pos_lut_sweep #(
  parameter int N_IN  = 3,
  parameter int DWELL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_ready,
  input  logic [N_IN-1:0] in_vec,
  input  logic            sweep_start,
  output logic            y,
  output logic            sweep_valid,
  output logic [N_IN-1:0] sweep_idx,
  output logic [N_IN:0]   ones_cnt,
  output logic            busy,
  output logic            done
);

  localparam int TBL = 1 << N_IN;
  localparam int DW  = $clog2(DWELL + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [DW-1:0]   DW_LAST = DW'(DWELL - 1);
  localparam logic [N_IN-1:0] K_LAST  = {N_IN{1'b1}};

  logic [1:0]      state_q, state_d;
  logic [TBL-1:0]  tbl_q, tbl_d;
  logic [DW-1:0]   dw_q, dw_d;
  logic [N_IN-1:0] k_q, k_d;
  logic            fin_q, fin_d;
  logic            y_q, y_d;
  logic            sv_q, sv_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [N_IN:0]   ones_q, ones_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            rdy_q, rdy_d;

  always_comb begin
    state_d = state_q;
    tbl_d   = tbl_q;
    dw_d    = dw_q;
    k_d     = k_q;
    fin_d   = fin_q;
    y_d     = y_q;
    sv_d    = 1'b0;
    idx_d   = idx_q;
    ones_d  = ones_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        y_d = tbl_q[in_vec];
        if (sweep_start) begin
          state_d = S_SWEEP;
          k_d     = '0;
          dw_d    = '0;
          ones_d  = '0;
          fin_d   = 1'b0;
        end else if (cfg_valid) begin
          tbl_d = {cfg_bit, tbl_q[TBL-1:1]};
        end
      end
      S_SWEEP: begin
        // one settle cycle after the last beat before the done pulse
        if (fin_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (dw_q == DW_LAST) begin
          dw_d   = '0;
          sv_d   = 1'b1;
          idx_d  = k_q;
          y_d    = tbl_q[k_q];
          ones_d = ones_q + {{N_IN{1'b0}}, tbl_q[k_q]};
          if (k_q == K_LAST) fin_d = 1'b1;
          else k_d = k_q + 1'b1;
        end else begin
          dw_d = dw_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    rdy_d  = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tbl_q   <= '0;
      dw_q    <= '0;
      k_q     <= '0;
      fin_q   <= 1'b0;
      y_q     <= 1'b0;
      sv_q    <= 1'b0;
      idx_q   <= '0;
      ones_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tbl_q   <= tbl_d;
      dw_q    <= dw_d;
      k_q     <= k_d;
      fin_q   <= fin_d;
      y_q     <= y_d;
      sv_q    <= sv_d;
      idx_q   <= idx_d;
      ones_q  <= ones_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

  assign cfg_ready   = rdy_q;
  assign y           = y_q;
  assign sweep_valid = sv_q;
  assign sweep_idx   = idx_q;
  assign ones_cnt    = ones_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_pos_lut_sweep.sv
// Bench for pos_lut_sweep: DWELL=1 and DWELL=3 instances share stimulus,
// sweep beats are checked against a queue of expected beats.
module tb_pos_lut_sweep;

  typedef struct {
    int idx;
    int y;
    int cyc;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_bit = 1'b0;
  logic [2:0] in_vec = '0;
  logic       sweep_start = 1'b0;

  logic       rdy1, y1, sv1, busy1, done1;
  logic [2:0] idx1;
  logic [3:0] ones1;
  logic       rdy3, y3, sv3, busy3, done3;
  logic [2:0] idx3;
  logic [3:0] ones3;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int c0 = 0;
  int exp_done1 = -1;
  int exp_done3 = -1;
  int dn1 = 0;
  int dn3 = 0;
  logic pd1 = 1'b0;
  logic pd3 = 1'b0;
  logic [7:0] tbl = '0;
  beat_t q1[$];
  beat_t q3[$];

  pos_lut_sweep #(.N_IN(3), .DWELL(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .cfg_ready(rdy1), .in_vec(in_vec), .sweep_start(sweep_start),
    .y(y1), .sweep_valid(sv1), .sweep_idx(idx1), .ones_cnt(ones1),
    .busy(busy1), .done(done1)
  );

  pos_lut_sweep #(.N_IN(3), .DWELL(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .cfg_ready(rdy3), .in_vec(in_vec), .sweep_start(sweep_start),
    .y(y3), .sweep_valid(sv3), .sweep_idx(idx3), .ones_cnt(ones3),
    .busy(busy3), .done(done3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (sv1) begin
      if (q1.size() == 0) chk("d1 extra beat", 1, 0);
      else begin
        e = q1.pop_front();
        chk("d1 idx", int'(idx1), e.idx);
        chk("d1 y", int'(y1), e.y);
        chk("d1 beat cyc", cyc, e.cyc);
      end
    end
    if (pd1) chk("d1 busy fall", int'(busy1), 0);
    if (done1) begin
      dn1++;
      chk("d1 done cyc", cyc, exp_done1);
      chk("d1 busy in done", int'(busy1), 1);
    end
    pd1 = done1;
  end

  always @(negedge clk) begin
    beat_t e;
    if (sv3) begin
      if (q3.size() == 0) chk("d3 extra beat", 1, 0);
      else begin
        e = q3.pop_front();
        chk("d3 idx", int'(idx3), e.idx);
        chk("d3 y", int'(y3), e.y);
        chk("d3 beat cyc", cyc, e.cyc);
      end
    end
    if (pd3) chk("d3 busy fall", int'(busy3), 0);
    if (done3) begin
      dn3++;
      chk("d3 done cyc", cyc, exp_done3);
      chk("d3 busy in done", int'(busy3), 1);
    end
    pd3 = done3;
  end

  task automatic load(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_bit = v[i];
      tbl = {cfg_bit, tbl[7:1]};
    end
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Drives a single-cycle start, optionally colliding with a cfg shift
  task automatic start(input logic with_cfg);
    beat_t b;
    @(negedge clk);
    sweep_start = 1'b1;
    cfg_valid = with_cfg;
    cfg_bit = 1'b1;
    c0 = cyc + 1;
    for (int k = 0; k < 8; k++) begin
      b.idx = k;
      b.y = int'(tbl[k]);
      b.cyc = c0 + (k + 1);
      q1.push_back(b);
      b.cyc = c0 + (k + 1) * 3;
      q3.push_back(b);
    end
    exp_done1 = c0 + 8 + 1;
    exp_done3 = c0 + 24 + 1;
    @(negedge clk);
    sweep_start = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy1 && !busy3) break;
    end
    chk("idle wait", int'(busy1 | busy3), 0);
    repeat (2) @(negedge clk);
    chk("d1 beats left", q1.size(), 0);
    chk("d3 beats left", q3.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " d1"}, int'({y1, sv1, idx1, ones1, busy1, done1, rdy1}), 0);
    chk({tag, " d3"}, int'({y3, sv3, idx3, ones3, busy3, done3, rdy3}), 0);
  endtask

  initial begin
    int lv[5] = '{0, 1, 4, 6, 7};
    int d1s, d3s;

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("d1 cfg_ready", int'(rdy1), 1);
    chk("d3 cfg_ready", int'(rdy3), 1);

    load(8'hB2);
    foreach (lv[i]) begin
      @(negedge clk);
      in_vec = 3'(lv[i]);
      @(negedge clk);
      chk("d1 live y", int'(y1), int'(tbl[in_vec]));
      chk("d3 live y", int'(y3), int'(tbl[in_vec]));
    end

    d1s = dn1;
    d3s = dn3;
    start(1'b1);
    @(negedge clk);
    chk("cfg_ready in sweep", int'(rdy1), 0);
    sweep_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_bit = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    @(negedge clk);
    cfg_valid = 1'b0;
    wait_idle();
    chk("d1 ones b2", int'(ones1), 4);
    chk("d3 ones b2", int'(ones3), 4);
    chk("d1 one done", dn1 - d1s, 1);
    chk("d3 one done", dn3 - d3s, 1);
    in_vec = 3'd7;
    @(negedge clk);
    chk("table kept", int'(y1), 1);

    tbl = '0;
    load(8'hFF);
    d1s = dn1;
    d3s = dn3;
    start(1'b0);
    wait_idle();
    chk("d1 ones ff", int'(ones1), 8);
    chk("d3 ones ff", int'(ones3), 8);
    chk("d3 one done ff", dn3 - d3s, 1);

    d1s = dn1;
    d3s = dn3;
    start(1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("mid reset");
    q1.delete();
    q3.delete();
    tbl = '0;
    exp_done1 = -1;
    exp_done3 = -1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("no done d1", dn1 - d1s, 0);
    chk("no done d3", dn3 - d3s, 0);

    start(1'b0);
    wait_idle();
    chk("d1 ones zero", int'(ones1), 0);
    chk("d3 ones zero", int'(ones3), 0);
    chk("d3 one done z", dn3 - d3s, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
